// File: rtl/iterative_alu.sv
// Multicycle ALU with a start/done handshake: single-cycle logic, arithmetic and shift
// operations, plus shift-add unsigned multiply and restoring unsigned divide.
module iterative_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            ALUop,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  zero,
  output logic                  div_by_zero
);

  localparam int DW = DATA_WIDTH;

  if ((DATA_WIDTH < 32'sd8) || ((DATA_WIDTH & (DATA_WIDTH - 32'sd1)) != 32'sd0)) begin : g_bad_width
    $error("iterative_alu: DATA_WIDTH must be a power of two and at least 8");
  end

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_WIDTH - 1);
  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [3:0]         op_r;
  logic [DW-1:0]      a_r;
  logic [DW-1:0]      b_r;
  logic [DW-1:0]      hi_r;
  logic [DW-1:0]      lo_r;
  logic [SHAMT_W-1:0] cnt_r;

  logic               busy_r;
  logic               done_r;
  logic [DW-1:0]      result_r;
  logic [DW-1:0]      result_hi_r;
  logic               zero_r;
  logic               dbz_r;

  logic [SHAMT_W-1:0] shamt_s;
  logic [DW-1:0]      exec_res_s;
  logic [DW-1:0]      exec_hi_s;
  logic               exec_dbz_s;

  logic [DW:0]        mul_sum_s;
  logic [DW-1:0]      mul_hi_s;
  logic [DW-1:0]      mul_lo_s;

  logic [DW:0]        div_shift_s;
  logic [DW:0]        div_diff_s;
  logic               div_fits_s;
  logic [DW-1:0]      div_hi_s;
  logic [DW-1:0]      div_lo_s;

  logic               capture_s;
  logic               load_s;
  logic [DW-1:0]      load_res_s;
  logic [DW-1:0]      load_hi_s;
  logic               load_dbz_s;

  assign shamt_s   = b_r[SHAMT_W-1:0];
  assign capture_s = (state_r == S_IDLE) && start;

  // Single-cycle datapath; an EXEC-path DIVU can only be the divide-by-zero case.
  always_comb begin
    exec_res_s = '0;
    exec_hi_s  = '0;
    exec_dbz_s = 1'b0;
    case (op_r)
      OP_ADD:  exec_res_s = a_r + b_r;
      OP_SUB:  exec_res_s = a_r - b_r;
      OP_AND:  exec_res_s = a_r & b_r;
      OP_OR:   exec_res_s = a_r | b_r;
      OP_XOR:  exec_res_s = a_r ^ b_r;
      OP_NOR:  exec_res_s = ~(a_r | b_r);
      OP_SLT:  exec_res_s = {{(DW-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
      OP_SLTU: exec_res_s = {{(DW-1){1'b0}}, (a_r < b_r)};
      OP_SLL:  exec_res_s = a_r << shamt_s;
      OP_SRL:  exec_res_s = a_r >> shamt_s;
      OP_SRA:  exec_res_s = $signed(a_r) >>> shamt_s;
      OP_DIVU: begin
        exec_res_s = '1;
        exec_hi_s  = a_r;
        exec_dbz_s = 1'b1;
      end
      default: exec_res_s = '0;
    endcase
  end

  // One shift-add multiply step: {hi,lo} holds partial product over the remaining multiplier bits.
  always_comb begin
    mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : {(DW+1){1'b0}});
    mul_hi_s  = mul_sum_s[DW:1];
    mul_lo_s  = {mul_sum_s[0], lo_r[DW-1:1]};
  end

  // One restoring-divide step: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    div_shift_s = {hi_r, lo_r[DW-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    div_fits_s  = ~div_diff_s[DW];
    if (div_fits_s) begin
      div_hi_s = div_diff_s[DW-1:0];
    end else begin
      div_hi_s = div_shift_s[DW-1:0];
    end
    div_lo_s = {lo_r[DW-2:0], div_fits_s};
  end

  // Next-state logic and selection of the values loaded into the output registers.
  always_comb begin
    state_s    = state_r;
    load_s     = 1'b0;
    load_res_s = '0;
    load_hi_s  = '0;
    load_dbz_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (ALUop == OP_MULU) begin
            state_s = S_MUL;
          end else if ((ALUop == OP_DIVU) && (b != '0)) begin
            state_s = S_DIV;
          end else begin
            state_s = S_EXEC;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_EXEC: begin
        load_s     = 1'b1;
        load_res_s = exec_res_s;
        load_hi_s  = exec_hi_s;
        load_dbz_s = exec_dbz_s;
        state_s    = S_DONE;
      end
      S_MUL: begin
        if (cnt_r == '0) begin
          load_s     = 1'b1;
          load_res_s = mul_lo_s;
          load_hi_s  = mul_hi_s;
          state_s    = S_DONE;
        end else begin
          state_s = S_MUL;
        end
      end
      S_DIV: begin
        if (cnt_r == '0) begin
          load_s     = 1'b1;
          load_res_s = div_lo_s;
          load_hi_s  = div_hi_s;
          state_s    = S_DONE;
        end else begin
          state_s = S_DIV;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register with registered busy/done derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == S_EXEC) || (state_s == S_MUL) || (state_s == S_DIV);
      done_r  <= (state_s == S_DONE);
    end
  end

  // Operand capture and iterative working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= 4'b0000;
      a_r   <= '0;
      b_r   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      cnt_r <= '0;
    end else if (capture_s) begin
      op_r  <= ALUop;
      a_r   <= a;
      b_r   <= b;
      hi_r  <= '0;
      lo_r  <= (ALUop == OP_DIVU) ? a : b;
      cnt_r <= CNT_LAST;
    end else if (state_r == S_MUL) begin
      hi_r  <= mul_hi_s;
      lo_r  <= mul_lo_s;
      cnt_r <= cnt_r - CNT_ONE;
    end else if (state_r == S_DIV) begin
      hi_r  <= div_hi_s;
      lo_r  <= div_lo_s;
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Output registers change only on a completion and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= '0;
      result_hi_r <= '0;
      zero_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else if (load_s) begin
      result_r    <= load_res_s;
      result_hi_r <= load_hi_s;
      zero_r      <= (load_res_s == '0);
      dbz_r       <= load_dbz_s;
    end else begin
      result_r    <= result_r;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign result      = result_r;
  assign result_hi   = result_hi_r;
  assign zero        = zero_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu at DATA_WIDTH 32 and 16, using directed cases
// and randomized operations against a plain-arithmetic reference model.
module tb_iterative_alu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start32, busy32, done32, zero32, dbz32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, res32, hi32;

  logic        start16, busy16, done16, zero16, dbz16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, res16, hi16;

  int n_checks = 0;
  int n_fail   = 0;

  iterative_alu #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .ALUop(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .result_hi(hi32),
    .zero(zero32), .div_by_zero(dbz32)
  );

  iterative_alu #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .ALUop(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(res16), .result_hi(hi16),
    .zero(zero16), .div_by_zero(dbz16)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 32) begin
      start32 = st; op32 = op; a32 = a[31:0]; b32 = b[31:0];
    end else begin
      start16 = st; op16 = op; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  task automatic sample(input int w, output logic [63:0] res, output logic [63:0] hi,
                        output logic bsy, output logic dn, output logic zr, output logic dz);
    if (w == 32) begin
      res = {32'd0, res32}; hi = {32'd0, hi32}; bsy = busy32; dn = done32; zr = zero32; dz = dbz32;
    end else begin
      res = {48'd0, res16}; hi = {48'd0, hi16}; bsy = busy16; dn = done16; zr = zero16; dz = dbz16;
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference model: what each opcode means arithmetically, plus its expected latency.
  task automatic model(input int w, input logic [3:0] op, input logic [63:0] ai, input logic [63:0] bi,
                       output logic [63:0] res, output logic [63:0] hi, output logic dz, output int lat);
    logic [63:0] m, a, b, aext, p;
    longint      sa, sb;
    int          sh;
    m  = wmask(w);
    a  = ai & m;
    b  = bi & m;
    sh = int'(b % 64'(w));
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    aext = a[w-1] ? (a | ~m) : a;
    res = 64'd0; hi = 64'd0; dz = 1'b0; lat = 1;
    case (op)
      4'd0:  res = (a + b) & m;
      4'd1:  res = (a - b) & m;
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a ^ b;
      4'd5:  res = ~(a | b) & m;
      4'd6:  res = (sa < sb) ? 64'd1 : 64'd0;
      4'd7:  res = (a < b) ? 64'd1 : 64'd0;
      4'd8:  res = (a << sh) & m;
      4'd9:  res = a >> sh;
      4'd10: res = 64'($signed(aext) >>> sh) & m;
      4'd11: begin
        p = a * b; res = p & m; hi = p >> w; lat = w;
      end
      4'd12: begin
        if (b == 64'd0) begin
          res = m; hi = a; dz = 1'b1;
        end else begin
          res = a / b; hi = a % b; lat = w;
        end
      end
      default: res = 64'd0;
    endcase
  endtask

  task automatic run_op(input int w, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input bit noisy, output logic [63:0] ores, output logic [63:0] ohi);
    logic [63:0] eres, ehi, res, hi;
    logic        edz, bsy, dn, zr, dz;
    int          lat, cyc;
    string       t;
    t = $sformatf("w%0d op%0d a=%0h b=%0h", w, op, a & wmask(w), b & wmask(w));
    model(w, op, a, b, eres, ehi, edz, lat);
    @(negedge clk);
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    sample(w, res, hi, bsy, dn, zr, dz);
    chk_eq({t, " busy@capture"}, {63'd0, bsy}, 64'd1);
    cyc = 0;
    dn  = 1'b0;
    while (!dn && cyc < 200) begin
      @(negedge clk);
      if (noisy && (cyc + 1 < lat))
        drive(w, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
      else
        drive(w, 1'b0, 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
      @(posedge clk); #1;
      sample(w, res, hi, bsy, dn, zr, dz);
      cyc++;
    end
    chk_eq({t, " latency"}, 64'(cyc), 64'(lat));
    chk_eq({t, " result"}, res, eres);
    chk_eq({t, " result_hi"}, hi, ehi);
    chk_eq({t, " zero"}, {63'd0, zr}, {63'd0, (eres == 64'd0)});
    chk_eq({t, " div_by_zero"}, {63'd0, dz}, {63'd0, edz});
    chk_eq({t, " busy@done"}, {63'd0, bsy}, 64'd0);
    @(posedge clk); #1;
    sample(w, res, hi, bsy, dn, zr, dz);
    chk_eq({t, " done pulse width"}, {63'd0, dn}, 64'd0);
    ores = eres;
    ohi  = ehi;
  endtask

  task automatic check_all_zero(input int w, input string tag);
    logic [63:0] res, hi;
    logic        bsy, dn, zr, dz;
    sample(w, res, hi, bsy, dn, zr, dz);
    chk_eq($sformatf("w%0d %s outputs", w, tag), {res[31:0], hi[27:0], bsy, dn, zr, dz}, 64'd0);
  endtask

  task automatic run_suite(input int w);
    logic [63:0] m, r, h, res, hi;
    logic        bsy, dn, zr, dz;
    bit          saw_done;
    m = wmask(w);
    // directed cases
    run_op(w, 4'd0, 64'h00FFFF00, 64'hFFFFFFAE, 1'b0, r, h);
    run_op(w, 4'd1, 64'h12345678, 64'h12345678, 1'b0, r, h);
    chk_eq($sformatf("w%0d sub self", w), r, 64'd0);
    run_op(w, 4'd6, m, 64'd1, 1'b0, r, h);
    chk_eq($sformatf("w%0d slt -1<1", w), r, 64'd1);
    run_op(w, 4'd7, m, 64'd1, 1'b0, r, h);
    chk_eq($sformatf("w%0d sltu max<1", w), r, 64'd0);
    run_op(w, 4'd5, 64'hF0F0F0F0, 64'h0F0F0F0F, 1'b0, r, h);
    run_op(w, 4'd10, 64'hF << (w - 4), 64'h24, 1'b0, r, h);
    chk_eq($sformatf("w%0d sra", w), r, (64'hFF << (w - 8)) & m);
    run_op(w, 4'd9, 64'hF << (w - 4), 64'h24, 1'b0, r, h);
    run_op(w, 4'd8, 64'hF << (w - 4), 64'h24, 1'b0, r, h);
    run_op(w, 4'd11, m, m, 1'b1, r, h);
    chk_eq($sformatf("w%0d mulu max hi", w), h, m - 64'd1);
    chk_eq($sformatf("w%0d mulu max lo", w), r, 64'd1);
    run_op(w, 4'd12, 64'd100, 64'd7, 1'b1, r, h);
    chk_eq($sformatf("w%0d divu 100/7", w), {h[31:0], r[31:0]}, {32'd2, 32'd14});
    run_op(w, 4'd12, 64'hF1, 64'd0, 1'b0, r, h);
    run_op(w, 4'd0, 64'd5, 64'd6, 1'b0, r, h);
    run_op(w, 4'd13, 64'd3, 64'd4, 1'b0, r, h);
    // randomized operations, with random start noise while busy
    for (int i = 0; i < 40; i++) begin
      logic [63:0] ra, rb;
      logic [3:0]  rop;
      rop = 4'($urandom_range(0, 15));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) rb = rb & 64'h7;
      if ($urandom_range(0, 7) == 0) ra = m;
      run_op(w, rop, ra, rb, 1'($urandom_range(0, 1)), r, h);
    end
    // reset in the middle of a MULU
    run_op(w, 4'd0, 64'd5, 64'd6, 1'b0, r, h);
    @(negedge clk);
    drive(w, 1'b1, 4'd11, m, m);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, 4'd0, 64'd0, 64'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero(w, "async reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < w + 4; c++) begin
      @(posedge clk); #1;
      sample(w, res, hi, bsy, dn, zr, dz);
      if (dn || bsy) saw_done = 1'b1;
    end
    chk_eq($sformatf("w%0d no activity after abort", w), {63'd0, saw_done}, 64'd0);
    run_op(w, 4'd0, 64'd1, 64'd2, 1'b0, r, h);
    chk_eq($sformatf("w%0d add after reset", w), r, 64'd3);
  endtask

  initial begin
    drive(32, 1'b0, 4'd0, 64'd0, 64'd0);
    drive(16, 1'b0, 4'd0, 64'd0, 64'd0);
    rst_n = 1'b0;
    #12;
    check_all_zero(32, "power-on reset");
    check_all_zero(16, "power-on reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_suite(32);
    run_suite(16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
